// File: rtl/test_harness_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : test_harness_ctrl_pkg
//  Purpose  : Shared state/verdict encodings and width helpers for the
//             regression run controller.
//  Revision : 1.0
// ============================================================================
package test_harness_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_RUN     = 3'd2,
        S_PASS    = 3'd3,
        S_FAIL    = 3'd4,
        S_TIMEOUT = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        VERDICT_NONE    = 2'd0,
        VERDICT_PASS    = 2'd1,
        VERDICT_FAIL    = 2'd2,
        VERDICT_TIMEOUT = 2'd3
    } verdict_e;

    // clog2 with a floor of one bit, so single-entry ranges still get a port
    function automatic int min1_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int cyc_width(input int timeout_cycles);
        return $clog2(timeout_cycles + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/test_harness_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : test_harness_ctrl_if
//  Purpose  : Bundle between the run controller and the monitored tests.
//  Revision : 1.0
// ============================================================================
interface test_harness_ctrl_if
    import test_harness_ctrl_pkg::*;
#(
    parameter int NUM_TESTS      = 14,
    parameter int TIMEOUT_CYCLES = 4096
) ();

    localparam int IDX_W = min1_clog2(NUM_TESTS);
    localparam int CYC_W = cyc_width(TIMEOUT_CYCLES);

    logic                 start;
    logic [NUM_TESTS-1:0] test_fail;
    logic [NUM_TESTS-1:0] test_finish;
    logic                 test_reset;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic                 fail;
    logic                 timeout;
    logic [IDX_W-1:0]     fail_index;
    logic [NUM_TESTS-1:0] finish_mask;
    logic [CYC_W-1:0]     cycle_count;

    // Controller side
    modport master (
        input  start, test_fail, test_finish,
        output test_reset, busy, done, pass, fail, timeout,
               fail_index, finish_mask, cycle_count
    );

    // Test/regression side
    modport slave (
        output start, test_fail, test_finish,
        input  test_reset, busy, done, pass, fail, timeout,
               fail_index, finish_mask, cycle_count
    );

endinterface
`default_nettype wire

// File: rtl/test_harness_ctrl_fail_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : test_harness_ctrl_fail_encoder
//  Purpose  : Lowest-set-bit priority encoder over the per-test fail vector.
//  Revision : 1.0
// ============================================================================
module test_harness_ctrl_fail_encoder
    import test_harness_ctrl_pkg::*;
#(
    parameter int NUM_TESTS = 14,
    parameter int IDX_W     = min1_clog2(NUM_TESTS)
) (
    input  wire logic [NUM_TESTS-1:0] i_vec,
    output logic      [IDX_W-1:0]     o_index,
    output logic                      o_valid
);

    // Scan downward so the lowest set bit is the last one written
    always_comb begin
        o_index = '0;
        for (int i = NUM_TESTS - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_index = IDX_W'(i);
            end
        end
    end

    assign o_valid = |i_vec;

endmodule
`default_nettype wire

// File: rtl/test_harness_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : test_harness_ctrl
//  Purpose  : Run controller/scoreboard: sequences test reset, then latches a
//             PASS / FAIL / TIMEOUT verdict with fail index and cycle count.
//  Revision : 1.0
// ============================================================================
module test_harness_ctrl
    import test_harness_ctrl_pkg::*;
#(
    parameter int NUM_TESTS      = 14,
    parameter int INIT_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    test_harness_ctrl_if.master bus
);

    localparam int IDX_W  = min1_clog2(NUM_TESTS);
    localparam int CYC_W  = cyc_width(TIMEOUT_CYCLES);
    localparam int INIT_W = min1_clog2(INIT_CYCLES);

    localparam logic [INIT_W-1:0] c_init_last    = INIT_W'(INIT_CYCLES - 1);
    localparam logic [CYC_W-1:0]  c_timeout_last = CYC_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CYC_W-1:0]  c_cyc_max      = CYC_W'(TIMEOUT_CYCLES);

    state_e               state_q,       state_d;
    logic                 test_reset_q,  test_reset_d;
    logic                 busy_q,        busy_d;
    logic                 done_q,        done_d;
    logic                 pass_q,        pass_d;
    logic                 fail_q,        fail_d;
    logic                 timeout_q,     timeout_d;
    logic [IDX_W-1:0]     fail_index_q,  fail_index_d;
    logic [NUM_TESTS-1:0] finish_mask_q, finish_mask_d;
    logic [CYC_W-1:0]     cycle_count_q, cycle_count_d;
    logic [INIT_W-1:0]    init_cnt_q,    init_cnt_d;

    logic [IDX_W-1:0]     enc_index;
    logic                 enc_valid;
    logic                 all_finished;

    test_harness_ctrl_fail_encoder #(
        .NUM_TESTS (NUM_TESTS),
        .IDX_W     (IDX_W)
    ) u_fail_encoder (
        .i_vec   (bus.test_fail),
        .o_index (enc_index),
        .o_valid (enc_valid)
    );

    // Includes this cycle's finishes so a completing pulse is seen at once
    assign all_finished = &(finish_mask_q | bus.test_finish);

    always_comb begin
        state_d       = state_q;
        fail_index_d  = fail_index_q;
        finish_mask_d = finish_mask_q;
        cycle_count_d = cycle_count_q;
        init_cnt_d    = init_cnt_q;

        case (state_q)
            S_IDLE, S_PASS, S_FAIL, S_TIMEOUT: begin
                if (bus.start) begin
                    state_d       = S_INIT;
                    fail_index_d  = '0;
                    finish_mask_d = '0;
                    cycle_count_d = '0;
                    init_cnt_d    = '0;
                end
            end
            S_INIT: begin
                if (init_cnt_q == c_init_last) begin
                    state_d = S_RUN;
                end else begin
                    init_cnt_d = init_cnt_q + INIT_W'(1);
                end
            end
            S_RUN: begin
                finish_mask_d = finish_mask_q | bus.test_finish;
                if (enc_valid) begin
                    state_d      = S_FAIL;
                    fail_index_d = enc_index;
                end else if (all_finished) begin
                    state_d = S_PASS;
                end else if (cycle_count_q == c_timeout_last) begin
                    state_d = S_TIMEOUT;
                end else if (cycle_count_q != c_cyc_max) begin
                    cycle_count_d = cycle_count_q + CYC_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flags are decoded from the next state so they register with it
        test_reset_d = (state_d != S_RUN);
        busy_d       = (state_d == S_INIT) || (state_d == S_RUN);
        done_d       = (state_d == S_PASS) || (state_d == S_FAIL) || (state_d == S_TIMEOUT);
        pass_d       = (state_d == S_PASS);
        fail_d       = (state_d == S_FAIL);
        timeout_d    = (state_d == S_TIMEOUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            test_reset_q  <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            timeout_q     <= 1'b0;
            fail_index_q  <= '0;
            finish_mask_q <= '0;
            cycle_count_q <= '0;
            init_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            test_reset_q  <= test_reset_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
            timeout_q     <= timeout_d;
            fail_index_q  <= fail_index_d;
            finish_mask_q <= finish_mask_d;
            cycle_count_q <= cycle_count_d;
            init_cnt_q    <= init_cnt_d;
        end
    end

    assign bus.test_reset  = test_reset_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.pass        = pass_q;
    assign bus.fail        = fail_q;
    assign bus.timeout     = timeout_q;
    assign bus.fail_index  = fail_index_q;
    assign bus.finish_mask = finish_mask_q;
    assign bus.cycle_count = cycle_count_q;

endmodule
`default_nettype wire

// File: tb/tb_test_harness_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_test_harness_ctrl
//  Purpose  : Directed and randomized run scenarios for test_harness_ctrl.
//  Revision : 1.0
// ============================================================================
module tb_test_harness_ctrl;
    import test_harness_ctrl_pkg::*;

    localparam int NT = 4;
    localparam int IC = 16;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    test_harness_ctrl_if #(.NUM_TESTS(NT), .TIMEOUT_CYCLES(TO)) bus ();

    test_harness_ctrl #(
        .NUM_TESTS      (NT),
        .INIT_CYCLES    (IC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Per-RUN-cycle stimulus, indexed by RUN cycle number
    logic [NT-1:0] fv [TO];
    logic [NT-1:0] fn [TO];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stim();
        for (int t = 0; t < TO; t++) begin
            fv[t] = '0;
            fn[t] = '0;
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".test_reset"},  32'(bus.test_reset),  1);
        chk({tag, ".busy"},        32'(bus.busy),        0);
        chk({tag, ".done"},        32'(bus.done),        0);
        chk({tag, ".pass"},        32'(bus.pass),        0);
        chk({tag, ".fail"},        32'(bus.fail),        0);
        chk({tag, ".timeout"},     32'(bus.timeout),     0);
        chk({tag, ".fail_index"},  32'(bus.fail_index),  0);
        chk({tag, ".finish_mask"}, 32'(bus.finish_mask), 0);
        chk({tag, ".cycle_count"}, 32'(bus.cycle_count), 0);
    endtask

    // Walks the run rules over the stimulus tables cycle by cycle
    task automatic predict(output verdict_e v, output int at, output logic [NT-1:0] mask,
                           output int idx);
        logic [NT-1:0] seen;
        logic [NT-1:0] lsb;
        seen = '0;
        v    = VERDICT_TIMEOUT;
        at   = TO - 1;
        idx  = 0;
        for (int c = 0; c < TO; c++) begin
            seen = seen | fn[c];
            if (fv[c] != '0) begin
                lsb = fv[c] & (~fv[c] + 1'b1);
                idx = $clog2(lsb);
                v   = VERDICT_FAIL;
                at  = c;
                break;
            end
            if (&seen) begin
                v  = VERDICT_PASS;
                at = c;
                break;
            end
        end
        mask = seen;
    endtask

    task automatic do_run(input string tag, input int abort_at, input bit rnd_start);
        verdict_e      v;
        int            at;
        int            idx;
        logic [NT-1:0] mask;
        logic [NT-1:0] seen;
        predict(v, at, mask, idx);

        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk({tag, ".start.cycle_count"}, 32'(bus.cycle_count), 0);
        chk({tag, ".start.finish_mask"}, 32'(bus.finish_mask), 0);
        chk({tag, ".start.done"},        32'(bus.done),        0);

        for (int i = 0; i < IC; i++) begin
            chk({tag, ".init.test_reset"}, 32'(bus.test_reset), 1);
            chk({tag, ".init.busy"},       32'(bus.busy),       1);
            bus.test_fail   = NT'($urandom);
            bus.test_finish = NT'($urandom);
            if (rnd_start) bus.start = 1'($urandom);
            step();
        end

        seen = '0;
        for (int c = 0; c <= at; c++) begin
            chk({tag, ".run.test_reset"},  32'(bus.test_reset),  0);
            chk({tag, ".run.cycle_count"}, 32'(bus.cycle_count), 32'(c));
            chk({tag, ".run.finish_mask"}, 32'(bus.finish_mask), 32'(seen));
            if (c == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk_idle({tag, ".abort"});
                bus.test_fail   = '0;
                bus.test_finish = '0;
                bus.start       = 1'b0;
                return;
            end
            bus.test_fail   = fv[c];
            bus.test_finish = fn[c];
            if (rnd_start) bus.start = 1'($urandom);
            step();
            seen = seen | fn[c];
        end
        bus.test_fail   = '0;
        bus.test_finish = '0;
        bus.start       = 1'b0;

        chk({tag, ".v.done"},        32'(bus.done),        1);
        chk({tag, ".v.busy"},        32'(bus.busy),        0);
        chk({tag, ".v.test_reset"},  32'(bus.test_reset),  1);
        chk({tag, ".v.pass"},        32'(bus.pass),        32'(v == VERDICT_PASS));
        chk({tag, ".v.fail"},        32'(bus.fail),        32'(v == VERDICT_FAIL));
        chk({tag, ".v.timeout"},     32'(bus.timeout),     32'(v == VERDICT_TIMEOUT));
        chk({tag, ".v.cycle_count"}, 32'(bus.cycle_count), 32'(at));
        chk({tag, ".v.finish_mask"}, 32'(bus.finish_mask), 32'(mask));
        chk({tag, ".v.fail_index"},  32'(bus.fail_index),  32'((v == VERDICT_FAIL) ? idx : 0));

        // Terminal state must hold without a start request
        step();
        chk({tag, ".hold.done"},        32'(bus.done),        1);
        chk({tag, ".hold.cycle_count"}, 32'(bus.cycle_count), 32'(at));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b1;
        bus.start       = 1'b0;
        bus.test_fail   = '0;
        bus.test_finish = '0;
        #2 rst_n = 1'b0;
        #1;
        chk_idle("reset");
        step();
        step();
        rst_n = 1'b1;
        step();
        chk_idle("post_reset");

        // All tests finish together at RUN cycle 10
        clear_stim();
        fn[10] = 4'hF;
        do_run("all_finish", -1, 1'b0);

        // Staggered pulses; test 3 completes the set at RUN cycle 9
        clear_stim();
        fn[3] = 4'b0001;
        fn[7] = 4'b0010;
        fn[2] = 4'b0100;
        fn[9] = 4'b1000;
        do_run("stagger", -1, 1'b0);

        // Restart from PASS, fail on test 3 after it already finished
        clear_stim();
        fn[1] = 4'b1000;
        fv[4] = 4'b1000;
        do_run("restart_fail3", -1, 1'b0);

        clear_stim();
        fv[5] = 4'b1010;
        do_run("fail_1010", -1, 1'b0);

        // Fail coincides with the finish that would complete the set
        clear_stim();
        fn[2] = 4'b1101;
        fn[5] = 4'b0010;
        fv[5] = 4'b1000;
        do_run("fail_vs_pass", -1, 1'b0);

        // Test 2 never finishes
        clear_stim();
        fn[5] = 4'b1011;
        do_run("timeout", -1, 1'b0);

        // Async reset during RUN cycle 20
        clear_stim();
        fn[3] = 4'b0011;
        do_run("abort", 20, 1'b0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("abort.idle.busy", 32'(bus.busy), 0);
            chk("abort.idle.test_reset", 32'(bus.test_reset), 1);
        end

        for (int r = 0; r < 16; r++) begin
            clear_stim();
            for (int c = 0; c < TO; c++) begin
                if ($urandom_range(0, 99) < 2) fv[c] = NT'($urandom_range(1, (1 << NT) - 1));
                for (int b = 0; b < NT; b++) begin
                    if ($urandom_range(0, 99) < 5) fn[c][b] = 1'b1;
                end
            end
            do_run($sformatf("rnd%0d", r), -1, 1'b1);
        end

        // Start held high relaunches straight from a terminal state
        bus.start = 1'b1;
        step();
        chk("held_start.busy", 32'(bus.busy), 1);
        chk("held_start.done", 32'(bus.done), 0);
        chk("held_start.cycle_count", 32'(bus.cycle_count), 0);
        bus.start = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
